// File: rtl/pal_bist_pkg.sv
// Shared types and constants for the PAL built-in self-test controller.
// Holds the FSM state encoding and the MISR compression step.
package pal_bist_pkg;

    localparam int MISR_W = 16;
    localparam int VEC_W  = 4;
    localparam int RESP_W = 5;

    localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // One MISR step: shift left, fold in the polynomial on MSB carry-out, XOR the response.
    function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] cur,
                                                    input logic [RESP_W-1:0] resp);
        logic [MISR_W-1:0] fb;
        fb = cur[MISR_W-1] ? MISR_POLY : '0;
        return {cur[MISR_W-2:0], 1'b0} ^ fb ^ {{(MISR_W-RESP_W){1'b0}}, resp};
    endfunction

endpackage

// File: rtl/pal_bist_misr.sv
// 16-bit multiple-input signature register compressing 5-bit PAL responses.
// Synchronous seed load takes priority over capture enable.
module pal_bist_misr
    import pal_bist_pkg::*;
#(
    parameter logic [MISR_W-1:0] SEED = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              en,
    input  logic [RESP_W-1:0] din,
    output logic [MISR_W-1:0] nxt,
    output logic [MISR_W-1:0] q
);

    logic [MISR_W-1:0] misr_q;
    logic [MISR_W-1:0] misr_d;

    always_comb begin
        nxt    = misr_step(misr_q, din);
        misr_d = misr_q;
        if (load) begin
            misr_d = SEED;
        end else if (en) begin
            misr_d = nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misr_q <= SEED;
        end else begin
            misr_q <= misr_d;
        end
    end

    assign q = misr_q;

endmodule

// File: rtl/pal_bist.sv
// BIST sweep controller: steps all 16 PAL input vectors, holds each for a settle
// time, compresses responses into the MISR and flags the final signature match.
module pal_bist
    import pal_bist_pkg::*;
#(
    parameter int unsigned       SETTLE_CYCLES = 1,
    parameter logic [MISR_W-1:0] SEED          = 16'h0000,
    parameter logic [MISR_W-1:0] GOLDEN_SIG    = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [VEC_W-1:0]  pal_in,
    input  logic [RESP_W-1:0] pal_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature
);

    localparam int               CNT_W    = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [VEC_W-1:0] VEC_ONE  = VEC_W'(1);
    localparam logic [VEC_W-1:0] VEC_LAST = '1;

    state_e            state_q, state_d;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pass_q, pass_d;
    logic              misr_load;
    logic              misr_en;
    logic [MISR_W-1:0] misr_nxt;
    logic [MISR_W-1:0] misr_q;

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        misr_load = 1'b0;
        misr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SETTLE;
                    vec_d     = '0;
                    cnt_d     = CNT_INIT;
                    pass_d    = 1'b0;
                    misr_load = 1'b1;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                misr_en = 1'b1;
                // The last vector finalises the verdict on the same edge the signature settles.
                if (vec_q == VEC_LAST) begin
                    pass_d  = (misr_nxt == GOLDEN_SIG);
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + VEC_ONE;
                    cnt_d   = CNT_INIT;
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    pal_bist_misr #(
        .SEED (SEED)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (misr_load),
        .en    (misr_en),
        .din   (pal_out),
        .nxt   (misr_nxt),
        .q     (misr_q)
    );

    assign pal_in    = vec_q;
    assign busy      = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign signature = misr_q;

endmodule
